// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced active-low key levels into press/release/long/repeat
// pulses plus a serialized valid/ready event stream. Define KEY_REPEAT_EN to enable auto-repeat.
module key_event_decoder #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int KEY_CNT   = 8,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  localparam int KW = (KEY_CNT > 1) ? $clog2(KEY_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_CNT-1:0] keys,
  output logic [KEY_CNT-1:0] press_pulse,
  output logic [KEY_CNT-1:0] release_pulse,
  output logic [KEY_CNT-1:0] long_pulse,
  output logic [KEY_CNT-1:0] repeat_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [KW-1:0]      evt_key,
  output logic [1:0]         evt_type,
  output logic               evt_overflow
);
  localparam int          DIV       = CLK_FREQ / 1000;
  localparam logic [31:0] TICK_LAST = 32'(DIV - 1);
  localparam logic [12:0] LONG_W    = 13'(LONG_MS);
`ifdef KEY_REPEAT_EN
  localparam logic [12:0] REP_W     = 13'(REPEAT_MS);
`endif

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

  logic [KEY_CNT-1:0] key_q_reg, fall, rise;
  logic [31:0]        presc_reg;
  logic               tick;
  logic [KEY_CNT-1:0] press_next, release_next, long_next;
  logic [KEY_CNT-1:0] press_reg, release_reg, long_reg;
`ifdef KEY_REPEAT_EN
  logic [KEY_CNT-1:0] repeat_next, repeat_reg;
`endif
  logic [KEY_CNT-1:0]      new_vld, slot_valid_reg, eff_valid, take_oh;
  logic [KEY_CNT-1:0][1:0] new_type, slot_type_reg, eff_type;
  logic                    evt_valid_reg, evt_overflow_reg, load, ovf_set;
  logic [KW-1:0]           evt_key_reg, sel;
  logic [1:0]              evt_type_reg;

  assign fall = key_q_reg & ~keys;
  assign rise = ~key_q_reg & keys;
  assign tick = (presc_reg == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q_reg <= '1;
      presc_reg <= '0;
    end else begin
      key_q_reg <= keys;
      presc_reg <= tick ? 32'd0 : presc_reg + 32'd1;
    end
  end

  genvar gi;
  for (gi = 0; gi < KEY_CNT; gi++) begin : g_key
    state_t      state_reg, state_next;
    logic [11:0] cnt_reg, cnt_next;
    logic [12:0] cnt_inc;
    logic        press_n, release_n, long_n;
`ifdef KEY_REPEAT_EN
    logic        repeat_n;
    assign repeat_next[gi] = repeat_n;
`endif
    assign press_next[gi]   = press_n;
    assign release_next[gi] = release_n;
    assign long_next[gi]    = long_n;
    assign cnt_inc          = {1'b0, cnt_reg} + 13'd1;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    // Release is checked first so it suppresses a same-cycle long/repeat event.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      press_n    = 1'b0;
      release_n  = 1'b0;
      long_n     = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_n   = 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (fall[gi]) begin
            press_n    = 1'b1;
            cnt_next   = '0;
            state_next = S_HELD;
          end
        end
        S_HELD: begin
          if (rise[gi]) begin
            release_n  = 1'b1;
            state_next = S_IDLE;
          end else if (tick) begin
            if (cnt_inc == LONG_W) begin
              long_n     = 1'b1;
              cnt_next   = '0;
              state_next = S_LONG;
            end else begin
              cnt_next = cnt_inc[11:0];
            end
          end
        end
        S_LONG: begin
          if (rise[gi]) begin
            release_n  = 1'b1;
            state_next = S_IDLE;
          end
`ifdef KEY_REPEAT_EN
          else if (tick) begin
            if (cnt_inc == REP_W) begin
              repeat_n = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt_inc[11:0];
            end
          end
`endif
        end
        default: state_next = S_IDLE;
      endcase
    end

`ifdef KEY_REPEAT_EN
    assign new_type[gi] = {long_reg[gi] | repeat_reg[gi], release_reg[gi] | repeat_reg[gi]};
`else
    assign new_type[gi] = {long_reg[gi], release_reg[gi]};
`endif
    // A freshly fired event is visible to the event register in the same cycle it is queued.
    assign eff_type[gi] = new_vld[gi] ? new_type[gi] : slot_type_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_reg   <= '0;
      release_reg <= '0;
      long_reg    <= '0;
    end else begin
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_reg <= '0;
    else     repeat_reg <= repeat_next;
  end
  assign new_vld      = press_reg | release_reg | long_reg | repeat_reg;
  assign repeat_pulse = repeat_reg;
`else
  assign new_vld      = press_reg | release_reg | long_reg;
  assign repeat_pulse = '0;
`endif

  assign eff_valid = slot_valid_reg | new_vld;
  assign load      = !evt_valid_reg || evt_ready;
  assign ovf_set   = |(new_vld & slot_valid_reg & ~take_oh);

  // Lowest-index pending slot wins; iterate downward so the last hit is the lowest.
  always_comb begin
    sel     = '0;
    take_oh = '0;
    for (int i = KEY_CNT - 1; i >= 0; i--) begin
      if (eff_valid[i]) begin
        sel        = KW'(i);
        take_oh    = '0;
        take_oh[i] = load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_reg   <= '0;
      slot_type_reg    <= '0;
      evt_valid_reg    <= 1'b0;
      evt_key_reg      <= '0;
      evt_type_reg     <= '0;
      evt_overflow_reg <= 1'b0;
    end else begin
      slot_valid_reg <= eff_valid & ~take_oh;
      slot_type_reg  <= eff_type;
      if (ovf_set) evt_overflow_reg <= 1'b1;
      if (load) begin
        evt_valid_reg <= |eff_valid;
        if (|eff_valid) begin
          evt_key_reg  <= sel;
          evt_type_reg <= eff_type[sel];
        end
      end
    end
  end

  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;
  assign evt_valid     = evt_valid_reg;
  assign evt_key       = evt_key_reg;
  assign evt_type      = evt_type_reg;
  assign evt_overflow  = evt_overflow_reg;
endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random key/ready traffic,
// every cycle compared against a tick-counting behavioural model.
module tb_key_event_decoder;
  localparam int CF = 10_000;
  localparam int KC = 4;
  localparam int LM = 5;
  localparam int RM = 2;
  localparam int DIV = CF / 1000;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [KC-1:0] keys;
  logic [KC-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic          evt_valid, evt_ready, evt_overflow;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_decoder #(.CLK_FREQ(CF), .KEY_CNT(KC), .LONG_MS(LM), .REPEAT_MS(RM)) dut (
    .clk(clk), .rst(rst), .keys(keys),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: ms ticks counted since press; -1 means not held.
  int          m_cycle;
  bit [KC-1:0] m_kq;
  int          m_t [KC];
  bit [KC-1:0] e_press, e_rel, e_long, e_rpt;
  bit          sv [KC];
  bit [1:0]    st [KC];
  bit          e_valid, e_ovf;
  bit [1:0]    e_key, e_type;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit          tk, load;
    bit [KC-1:0] np, nr, nl, nrp;
    int          sel;
    if (rst) begin
      m_cycle = 0; m_kq = '1;
      for (int i = 0; i < KC; i++) begin m_t[i] = -1; sv[i] = 0; st[i] = 0; end
      e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
      e_valid = 0; e_key = 0; e_type = 0; e_ovf = 0;
      return;
    end
    tk = ((m_cycle % DIV) == DIV - 1);
    m_cycle++;
    np = 0; nr = 0; nl = 0; nrp = 0;
    for (int i = 0; i < KC; i++) begin
      if (m_t[i] < 0) begin
        if (m_kq[i] && !keys[i]) begin np[i] = 1; m_t[i] = 0; end
      end else if (!m_kq[i] && keys[i]) begin
        nr[i] = 1; m_t[i] = -1;
      end else if (tk) begin
        m_t[i]++;
        if (m_t[i] == LM) nl[i] = 1;
        else if (REP_EN && m_t[i] > LM && ((m_t[i] - LM) % RM) == 0) nrp[i] = 1;
      end
    end
    m_kq = keys;
    // queue the events announced by the pulses currently on the outputs
    load = !e_valid || evt_ready;
    sel = -1;
    for (int i = 0; i < KC; i++) begin
      bit nv;
      nv = e_press[i] | e_rel[i] | e_long[i] | e_rpt[i];
      if (sel < 0 && (sv[i] || nv)) sel = i;
    end
    for (int i = 0; i < KC; i++) begin
      if (e_press[i] | e_rel[i] | e_long[i] | e_rpt[i]) begin
        if (sv[i] && !(load && sel == i)) e_ovf = 1;
        sv[i] = 1;
        st[i] = e_press[i] ? 2'b00 : e_rel[i] ? 2'b01 : e_long[i] ? 2'b10 : 2'b11;
      end
    end
    if (load) begin
      if (sel >= 0) begin
        e_valid = 1; e_key = 2'(sel); e_type = st[sel]; sv[sel] = 0;
      end else begin
        e_valid = 0;
      end
    end
    e_press = np; e_rel = nr; e_long = nl; e_rpt = nrp;
  endtask

  task automatic drive_cycle(input logic r, input logic [KC-1:0] k, input logic rdy);
    rst = r; keys = k; evt_ready = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("press_pulse", 32'(press_pulse), 32'(e_press));
    check_val("release_pulse", 32'(release_pulse), 32'(e_rel));
    check_val("long_pulse", 32'(long_pulse), 32'(e_long));
    check_val("repeat_pulse", 32'(repeat_pulse), 32'(e_rpt));
    check_val("evt_valid", 32'(evt_valid), 32'(e_valid));
    check_val("evt_key", 32'(evt_key), 32'(e_key));
    check_val("evt_type", 32'(evt_type), 32'(e_type));
    check_val("evt_overflow", 32'(evt_overflow), 32'(e_ovf));
  endtask

  task automatic run(input int n, input logic [KC-1:0] k, input logic rdy);
    for (int c = 0; c < n; c++) drive_cycle(1'b0, k, rdy);
  endtask

  initial begin
    logic [KC-1:0] k;
    logic          r, rdy;
    rst = 1'b1; keys = '1; evt_ready = 1'b0;
    @(negedge clk);
    // reset with all keys released
    for (int c = 0; c < 50; c++) drive_cycle(1'b1, 4'b1111, 1'b0);
    run(10, 4'b1111, 1'b1);
    // short press on key 2
    run(20, 4'b1011, 1'b1);
    run(10, 4'b1111, 1'b1);
    // long hold on key 1
    run(100, 4'b1101, 1'b1);
    run(10, 4'b1111, 1'b1);
    // all keys at once
    run(10, 4'b0000, 1'b1);
    run(10, 4'b1111, 1'b1);
    // consumer stalled: slot overwrite and overflow
    run(3, 4'b1110, 1'b0);
    run(3, 4'b1111, 1'b0);
    run(3, 4'b1110, 1'b0);
    run(6, 4'b1110, 1'b1);
    run(10, 4'b1111, 1'b1);
    // reset while key 3 is in long-press, key kept low through reset
    run(80, 4'b0111, 1'b1);
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, 4'b0111, 1'b1);
    run(20, 4'b0111, 1'b1);
    run(10, 4'b1111, 1'b1);
    // random traffic
    k = 4'b1111;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < KC; b++)
        if ($urandom_range(0, 39) == 0) k[b] = ~k[b];
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 999) == 0);
      drive_cycle(r, k, rdy);
    end
    run(20, 4'b1111, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
